// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and types for the arbitrated adder
//
// Purpose : holds the default operand width, the FSM state encoding and the
//           requester ids used by adder_arb and the bench.
// Ports   : none (package).

package adder_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - plain combinational WIDTH-bit adder, carry discarded
//
// Purpose : shared adder used by adder_arb; any overflow handling lives in
//           the caller.
// Ports   : a, b  - operands (WIDTH)
//           sum   - a + b modulo 2^WIDTH (WIDTH)

module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/adder_arb.sv
// rtl/adder_arb.sv - two-requester round-robin arbiter feeding one shared adder
//
// Purpose : accepts an operand pair from one of two requesters, adds it with
//           a single shared adder and presents the sum until the consumer
//           takes it. One transaction in flight at a time (IDLE -> ADD -> OUT).
// Config  : define ADDER_ARB_SAT_EN for an unsigned saturating sum; without
//           it the sum wraps modulo 2^WIDTH.
// Ports   : CLK                    - clock, rising edge
//           RES                    - synchronous active-high reset
//           req0_valid/a/b/ready   - requester 0 handshake and operands
//           req1_valid/a/b/ready   - requester 1 handshake and operands
//           res_valid/id/sum       - result register and its owner
//           res_ready              - consumer takes the result
//           op_count               - completed transactions (16-bit, wraps)

module adder_arb
    import adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic             res_id,
    output logic [WIDTH-1:0] res_sum,
    input  logic             res_ready,
    output logic [15:0]      op_count
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_last_id;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_res_valid;
    logic             r_res_id;
    logic [WIDTH-1:0] r_res_sum;
    logic [15:0]      r_op_count;

    logic             w_grant_id;
    logic             w_accept;
    logic             w_complete;
    logic             w_req0_ready;
    logic             w_req1_ready;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [WIDTH-1:0] w_add_sum;
    logic [WIDTH-1:0] w_sum_final;

    // Round-robin: a lone requester always wins; on a tie the requester that
    // was not granted last wins. r_last_id resets to REQ1 so REQ0 takes the
    // first tie.
    always_comb begin
        w_grant_id = REQ0;
        if (req0_valid && req1_valid) begin
            w_grant_id = (r_last_id == REQ0) ? REQ1 : REQ0;
        end else if (req1_valid) begin
            w_grant_id = REQ1;
        end
    end

    assign w_sel_a = (w_grant_id == REQ1) ? req1_a : req0_a;
    assign w_sel_b = (w_grant_id == REQ1) ? req1_b : req0_b;

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready is gated by RES so no requester sees a handshake while the block
    // is being reset, even in the cycle reset is first applied.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if ((req0_valid || req1_valid) && !RES) begin
                    w_accept     = 1'b1;
                    w_req0_ready = (w_grant_id == REQ0);
                    w_req1_ready = (w_grant_id == REQ1);
                    w_state_nxt  = ADD;
                end
            end
            ADD: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a   (r_op_a),
        .b   (r_op_b),
        .sum (w_add_sum)
    );

`ifdef ADDER_ARB_SAT_EN
    // Unsigned overflow shows up as a wrapped sum smaller than an operand.
    logic w_carry;
    assign w_carry     = (w_add_sum < r_op_a);
    assign w_sum_final = w_carry ? {WIDTH{1'b1}} : w_add_sum;
`else
    assign w_sum_final = w_add_sum;
`endif

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_last_id   <= REQ1;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= REQ0;
            r_res_sum   <= '0;
            r_op_count  <= 16'd0;
        end else begin
            if (w_accept) begin
                r_op_a    <= w_sel_a;
                r_op_b    <= w_sel_b;
                r_last_id <= w_grant_id;
            end
            if (r_state == ADD) begin
                r_res_sum   <= w_sum_final;
                r_res_id    <= r_last_id;
                r_res_valid <= 1'b1;
            end
            if (w_complete) begin
                r_res_valid <= 1'b0;
                r_op_count  <= r_op_count + 16'd1;
            end
        end
    end

    assign req0_ready = w_req0_ready;
    assign req1_ready = w_req1_ready;
    assign res_valid  = r_res_valid;
    assign res_id     = r_res_id;
    assign res_sum    = r_res_sum;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_adder_arb.sv
// tb/tb_adder_arb.sv - directed scoreboard bench for adder_arb

module tb_adder_arb;

    localparam int W = 16;

    logic         CLK;
    logic         RES;
    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;
    logic         res_valid;
    logic         res_id;
    logic [W-1:0] res_sum;
    logic         res_ready;
    logic [15:0]  op_count;

    typedef struct packed {
        logic         id;
        logic [W-1:0] sum;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pops   = 0;
    logic acc0;
    logic acc1;

    adder_arb #(.WIDTH(W)) dut (
        .CLK        (CLK),
        .RES        (RES),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_sum    (res_sum),
        .res_ready  (res_ready),
        .op_count   (op_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ADDER_ARB_SAT_EN
        return s[W] ? {W{1'b1}} : s[W-1:0];
`else
        return s[W-1:0];
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called just after a negedge: samples handshakes for the coming edge,
    // updates the scoreboard, then advances to the next negedge.
    task automatic cycle();
        exp_t e;
        #1;
        acc0 = req0_ready;
        acc1 = req1_ready;
        check("ready_onehot", {31'd0, acc0 & acc1}, 32'd0);
        if (acc0) begin
            e.id = 1'b0; e.sum = model_sum(req0_a, req0_b);
            sb.push_back(e);
        end
        if (acc1) begin
            e.id = 1'b1; e.sum = model_sum(req1_a, req1_b);
            sb.push_back(e);
        end
        if (res_valid && res_ready && !RES) begin
            check("sb_underflow", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_res_id", {31'd0, res_id}, {31'd0, e.id});
                check("sb_res_sum", {16'd0, res_sum}, {16'd0, e.sum});
            end
            n_pops++;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run_txn(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        int   start;
        logic done;
        logic granted;
        start   = n_pops;
        done    = 1'b0;
        granted = 1'b0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        res_ready = 1'b1;
        for (int i = 0; i < 12 && !done; i++) begin
            cycle();
            if (acc0) begin req0_valid = 1'b0; if (!id) granted = 1'b1; end
            if (acc1) begin req1_valid = 1'b0; if (id) granted = 1'b1; end
            if (n_pops != start) done = 1'b1;
        end
        check("txn_granted", {31'd0, granted}, 32'd1);
        check("txn_done", {31'd0, done}, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        int   start;
        logic drained;

        RES = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0;
        @(negedge CLK);
        #1;
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        cycle();
        cycle();
        #1;
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_id", {31'd0, res_id}, 32'd0);
        check("rst_res_sum", {16'd0, res_sum}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        RES = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        cycle();
        cycle();
        #1;
        check("idle_ready_ignored_cnt", {16'd0, op_count}, 32'd0);
        check("idle_ready_ignored_vld", {31'd0, res_valid}, 32'd0);

        // Single requester, basic latency
        req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0001;
        #1;
        check("t1_ready0", {31'd0, req0_ready}, 32'd1);
        check("t1_ready1", {31'd0, req1_ready}, 32'd0);
        cycle();
        req0_valid = 1'b0;
        #1;
        check("t1_add_valid", {31'd0, res_valid}, 32'd0);
        check("t1_add_ready0", {31'd0, req0_ready}, 32'd0);
        cycle();
        #1;
        check("t1_res_valid", {31'd0, res_valid}, 32'd1);
        check("t1_res_id", {31'd0, res_id}, 32'd0);
        check("t1_res_sum", {16'd0, res_sum}, 32'h0004);
        check("t1_cnt_before", {16'd0, op_count}, 32'd0);
        cycle();
        #1;
        check("t1_cnt_after", {16'd0, op_count}, 32'd1);
        check("t1_valid_clr", {31'd0, res_valid}, 32'd0);

        // Tie after reset (requester 0 was granted last before reset)
        RES = 1'b1;
        cycle();
        RES = 1'b0;
        sb.delete();
        req0_valid = 1'b1; req0_a = 16'h000C; req0_b = 16'h0002;
        req1_valid = 1'b1; req1_a = 16'h0030; req1_b = 16'h0005;
        #1;
        check("t2_tie_ready0", {31'd0, req0_ready}, 32'd1);
        check("t2_tie_ready1", {31'd0, req1_ready}, 32'd0);
        cycle();
        req0_valid = 1'b0;
        #1;
        check("t2_add_ready0", {31'd0, req0_ready}, 32'd0);
        check("t2_add_ready1", {31'd0, req1_ready}, 32'd0);
        cycle();
        #1;
        check("t2_out_ready1", {31'd0, req1_ready}, 32'd0);
        check("t2_res0_id", {31'd0, res_id}, 32'd0);
        check("t2_res0_sum", {16'd0, res_sum}, 32'h000E);
        cycle();
        #1;
        check("t2_ready1", {31'd0, req1_ready}, 32'd1);
        check("t2_ready0", {31'd0, req0_ready}, 32'd0);
        cycle();
        req1_valid = 1'b0;
        cycle();
        #1;
        check("t2_res1_valid", {31'd0, res_valid}, 32'd1);
        check("t2_res1_id", {31'd0, res_id}, 32'd1);
        check("t2_res1_sum", {16'd0, res_sum}, 32'h0035);
        cycle();
        #1;
        check("t2_cnt", {16'd0, op_count}, 32'd2);

        // Back-pressure: result held for 5 cycles
        req0_valid = 1'b1; req0_a = 16'h0030; req0_b = 16'h0003; res_ready = 1'b0;
        cycle();
        req0_valid = 1'b0;
        cycle();
        req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_hold_valid", {31'd0, res_valid}, 32'd1);
            check("t3_hold_sum", {16'd0, res_sum}, 32'h0033);
            check("t3_hold_id", {31'd0, res_id}, 32'd0);
            check("t3_hold_cnt", {16'd0, op_count}, 32'd2);
            check("t3_hold_ready1", {31'd0, req1_ready}, 32'd0);
            cycle();
        end
        req1_valid = 1'b0; res_ready = 1'b1;
        cycle();
        #1;
        check("t3_cnt_once", {16'd0, op_count}, 32'd3);
        check("t3_valid_clr", {31'd0, res_valid}, 32'd0);

        // Overflow boundaries (wrap or saturate depending on build)
        run_txn(1'b0, 16'hFFFF, 16'h0002);
        run_txn(1'b1, 16'h8000, 16'h8000);
        run_txn(1'b0, 16'hFFFF, 16'h0000);
        run_txn(1'b1, 16'h1234, 16'h4321);
        #1;
        check("t4_cnt", {16'd0, op_count}, 32'd7);

        // Reset while requester 1's pair is in the ADD state
        req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0006; res_ready = 1'b1;
        #1;
        check("t5_ready1", {31'd0, req1_ready}, 32'd1);
        cycle();
        req1_valid = 1'b0;
        RES = 1'b1; req0_valid = 1'b1;
        #1;
        check("t5_res_ready0", {31'd0, req0_ready}, 32'd0);
        cycle();
        sb.delete();
        RES = 1'b0; req0_valid = 1'b0;
        #1;
        check("t5_res_valid", {31'd0, res_valid}, 32'd0);
        check("t5_op_count", {16'd0, op_count}, 32'd0);
        check("t5_res_sum", {16'd0, res_sum}, 32'd0);
        cycle();
        cycle();
        #1;
        check("t5_discarded", {31'd0, res_valid}, 32'd0);
        req0_valid = 1'b1; req0_a = 16'h0100; req0_b = 16'h0001;
        req1_valid = 1'b1; req1_a = 16'h0200; req1_b = 16'h0002;
        #1;
        check("t5_tie_ready0", {31'd0, req0_ready}, 32'd1);
        check("t5_tie_ready1", {31'd0, req1_ready}, 32'd0);
        start   = n_pops;
        drained = 1'b0;
        for (int i = 0; i < 15 && !drained; i++) begin
            cycle();
            if (acc0) req0_valid = 1'b0;
            if (acc1) req1_valid = 1'b0;
            if (n_pops - start == 2) drained = 1'b1;
        end
        check("t5_drained", {31'd0, drained}, 32'd1);
        #1;
        check("t5_cnt", {16'd0, op_count}, 32'd2);

        // Counter wrap: preset near the top, then complete two transactions
        force dut.r_op_count = 16'hFFFE;
        #1;
        release dut.r_op_count;
        @(negedge CLK);
        run_txn(1'b0, 16'h0001, 16'h0001);
        #1;
        check("t6_cnt_ffff", {16'd0, op_count}, 32'h0000FFFF);
        run_txn(1'b1, 16'h0002, 16'h0002);
        #1;
        check("t6_cnt_wrap", {16'd0, op_count}, 32'h00000000);

        check("sb_empty_end", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
